// File: rtl/gates_tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gates_tt_sweep_ctrl
//
// Self-test sequencer for a two-input basic-gate block. A start pulse launches
// a sweep over the four input vectors (a,b) = 00, 01, 10, 11. Each vector is
// held for SETTLE_CYCLES cycles. The gate outputs are then sampled for one
// cycle and compared against the ideal truth table. Mismatches accumulate
// into a per-gate error mask. The first failing vector is captured, and
// pass/fail is reported with a one-cycle done pulse.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin a sweep (accepted only while idle)
//   abort      in   1  terminate a sweep and return to idle
//   gate_res   in   8  {xnor,xor,nor,nand,or,and,not_b,not_a} from gate block
//   drv_a      out  1  input a to the gate block
//   drv_b      out  1  input b to the gate block
//   busy       out  1  sweep in progress (settling or checking)
//   done       out  1  one-cycle pulse when a sweep completes (not on abort)
//   pass       out  1  1 = no gate mismatched (valid with/after done)
//   err_mask   out  8  bit i set = gate_res[i] mismatched on some vector
//   fail_vec   out  2  vector {a,b} of the first mismatch
//   fail_valid out  1  fail_vec holds a captured mismatch
// -----------------------------------------------------------------------------
module gates_tt_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] gate_res,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_mask,
    output logic [1:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last value of the settle counter before moving on to CHECK.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // Truth tables of the eight gates, one nibble per gate. Nibble bit n is the
    // expected output for vector n = {a,b}. Gate 0 (not_a) sits in the low
    // nibble:
    //   xnor=1001 xor=0110 nor=0001 nand=0111 or=1110 and=1000 not_b=0101
    //   not_a=0011
    localparam logic [31:0] GATE_TT = 32'h9617_E853;

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [1:0]  vec_q,        vec_d;
    logic [7:0]  err_mask_q,   err_mask_d;
    logic        pass_q,       pass_d;
    logic [1:0]  fail_vec_q,   fail_vec_d;
    logic        fail_valid_q, fail_valid_d;

    logic [7:0]  expected_res;
    logic [7:0]  mismatch;

    // Expected gate outputs for the vector currently being driven.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_expected
            localparam logic [3:0] TT = GATE_TT[gi*4 +: 4];
            assign expected_res[gi] = TT[vec_q];
        end
    endgenerate

    assign mismatch = gate_res ^ expected_res;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            vec_q        <= 2'd0;
            err_mask_q   <= 8'd0;
            pass_q       <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            err_mask_q   <= err_mask_d;
            pass_q       <= pass_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        err_mask_d   = err_mask_q;
        pass_d       = pass_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            ST_IDLE: begin
                // abort takes priority over start, and nothing is cleared.
                if (start && !abort) begin
                    err_mask_d   = 8'd0;
                    pass_d       = 1'b0;
                    fail_vec_d   = 2'd0;
                    fail_valid_d = 1'b0;
                    vec_d        = 2'd0;
                    cnt_d        = 4'd0;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    // The sample taken in this cycle is discarded.
                    state_d = ST_IDLE;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                end else begin
                    err_mask_d = err_mask_q | mismatch;
                    if ((mismatch != 8'd0) && !fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                    // vec wraps 3 -> 0 so the gate inputs return to 00 once
                    // the sweep finishes.
                    vec_d = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        // Include this final compare in the verdict.
                        pass_d  = ((err_mask_q | mismatch) == 8'd0);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = 2'd0;
                cnt_d   = 4'd0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // -------------------------------------------------------------------------
    assign drv_a      = vec_q[1];
    assign drv_b      = vec_q[0];
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_mask   = err_mask_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_gates_tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for gates_tt_sweep_ctrl.
// Two instances share the control inputs: dut0 has SETTLE_CYCLES=2 and dut1
// has SETTLE_CYCLES=1. Each instance drives its own emulated gate block, and
// that block can be given a fault. A timeline model predicts every output
// each cycle from the time elapsed since the accepted start. Directed tests
// add literal expectations for latency, masks and fail vectors.
// -----------------------------------------------------------------------------
module tb_gates_tt_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort;
    int   fault_mode;

    logic       drv_a0, drv_b0, busy0, done0, pass0, fvalid0;
    logic [7:0] err0, gres0;
    logic [1:0] fvec0;
    logic       drv_a1, drv_b1, busy1, done1, pass1, fvalid1;
    logic [7:0] err1, gres1;
    logic [1:0] fvec1;

    int errors = 0;
    int checks = 0;

    // Ideal gate outputs {xnor,xor,nor,nand,or,and,not_b,not_a}.
    function automatic logic [7:0] ideal_tt(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~b, ~a};
    endfunction

    // Emulated gate block. Mode 0 is ideal, 1 is AND stuck-at-1,
    // 2 swaps XOR and XNOR, and 3 is OR stuck-at-0.
    function automatic logic [7:0] gate_fn(input logic a, input logic b, input int mode);
        logic [7:0] r;
        logic [7:0] id;
        id = ideal_tt(a, b);
        r  = id;
        case (mode)
            1: r[2] = 1'b1;
            2: begin r[7] = id[6]; r[6] = id[7]; end
            3: r[3] = 1'b0;
            default: ;
        endcase
        return r;
    endfunction

    assign gres0 = gate_fn(drv_a0, drv_b0, fault_mode);
    assign gres1 = gate_fn(drv_a1, drv_b1, fault_mode);

    gates_tt_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_res(gres0),
        .drv_a(drv_a0), .drv_b(drv_b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_mask(err0), .fail_vec(fvec0), .fail_valid(fvalid0)
    );

    gates_tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_res(gres1),
        .drv_a(drv_a1), .drv_b(drv_b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err1), .fail_vec(fvec1), .fail_valid(fvalid1)
    );

    // ---------------------------------------------------------------------
    // Timeline model. m_t is the cycle index within a sweep: 0 = idle,
    // 1..L = sweep cycles with L = 4*(S+1), and L+1 = done cycle. The vector
    // sampled at sweep cycle t is (t-1)/(S+1). A compare happens at each
    // t that is a multiple of S+1.
    // ---------------------------------------------------------------------
    localparam int SC [2] = '{2, 1};
    int         m_t      [2];
    logic [7:0] m_err    [2];
    logic       m_pass   [2];
    logic [1:0] m_fvec   [2];
    logic       m_fvalid [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_err[i] = '0; m_pass[i] = 1'b0; m_fvec[i] = '0; m_fvalid[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int L;
                int v;
                logic [7:0] mm;
                L = 4 * (SC[i] + 1);
                if (rst) begin
                    m_t[i] = 0; m_err[i] = '0; m_pass[i] = 1'b0; m_fvec[i] = '0; m_fvalid[i] = 1'b0;
                end else if (m_t[i] == 0) begin
                    if (start && !abort) begin
                        m_err[i] = '0; m_pass[i] = 1'b0; m_fvec[i] = '0; m_fvalid[i] = 1'b0;
                        m_t[i] = 1;
                    end
                end else if (abort) begin
                    m_t[i] = 0;
                end else if (m_t[i] <= L) begin
                    if (m_t[i] % (SC[i] + 1) == 0) begin
                        v  = m_t[i] / (SC[i] + 1) - 1;
                        mm = gate_fn(v[1], v[0], fault_mode) ^ ideal_tt(v[1], v[0]);
                        m_err[i] = m_err[i] | mm;
                        if (mm != 8'd0 && !m_fvalid[i]) begin
                            m_fvec[i] = 2'(v); m_fvalid[i] = 1'b1;
                        end
                        if (m_t[i] == L) m_pass[i] = (m_err[i] == 8'd0);
                    end
                    m_t[i] = m_t[i] + 1;
                end else begin
                    m_t[i] = 0;
                end
            end
        end
    end

    // Expected outputs packed as {drv_a,drv_b,busy,done,pass,fail_valid,fail_vec,err_mask}.
    function automatic logic [15:0] exp_pack(input int i);
        int L;
        logic [1:0] drv;
        logic bsy, dn;
        L   = 4 * (SC[i] + 1);
        bsy = (m_t[i] >= 1) && (m_t[i] <= L);
        dn  = (m_t[i] == L + 1);
        drv = bsy ? 2'((m_t[i] - 1) / (SC[i] + 1)) : 2'd0;
        return {drv, bsy, dn, m_pass[i], m_fvalid[i], m_fvec[i], m_err[i]};
    endfunction

    logic [15:0] act0, act1;
    assign act0 = {drv_a0, drv_b0, busy0, done0, pass0, fvalid0, fvec0, err0};
    assign act1 = {drv_a1, drv_b1, busy1, done1, pass1, fvalid1, fvec1, err1};

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (act0 !== exp_pack(0)) begin
                errors++;
                $display("FAIL model_dut0 t=%0t: got %h required %h ({drv,busy,done,pass,fvalid,fvec,err})",
                         $time, act0, exp_pack(0));
            end
            checks++;
            if (act1 !== exp_pack(1)) begin
                errors++;
                $display("FAIL model_dut1 t=%0t: got %h required %h ({drv,busy,done,pass,fvalid,fvec,err})",
                         $time, act1, exp_pack(1));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus helpers
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         lat0, lat1, nd0;
    logic [1:0] dv0 [4];

    // Pulses start and then watches 30 cycles. j counts cycles after the
    // sampling edge, so j=13 is "k+13". Optionally re-pulses start at
    // cycle repulse_j.
    task automatic run_sweep(input int repulse_j);
        lat0 = -1; lat1 = -1; nd0 = 0;
        for (int n = 0; n < 4; n++) dv0[n] = 2'bxx;
        start = 1'b1;
        tick();
        for (int j = 1; j <= 30; j++) begin
            start = (j == repulse_j);
            if (done0) begin
                nd0++;
                if (lat0 < 0) lat0 = j;
            end
            if (done1 && lat1 < 0) lat1 = j;
            if (j % 3 == 1 && j <= 10) dv0[j / 3] = {drv_a0, drv_b0};
            tick();
        end
        start = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; fault_mode = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_outputs", 32'(act0), 32'h0);

        // Ideal gates.
        run_sweep(0);
        check("t1_latency", 32'(lat0), 32'd13);
        check("t1_latency_s1", 32'(lat1), 32'd9);
        check("t1_drv_seq", 32'({dv0[0], dv0[1], dv0[2], dv0[3]}), 32'h1B);
        check("t1_pass", 32'(pass0), 32'd1);
        check("t1_err_mask", 32'(err0), 32'h00);
        check("t1_fail_valid", 32'(fvalid0), 32'd0);

        // AND stuck-at-1.
        fault_mode = 1;
        run_sweep(0);
        check("t2_err_mask", 32'(err0), 32'h04);
        check("t2_fail_vec", 32'(fvec0), 32'd0);
        check("t2_fail_valid", 32'(fvalid0), 32'd1);
        check("t2_pass", 32'(pass0), 32'd0);

        // XOR/XNOR swapped.
        fault_mode = 2;
        run_sweep(0);
        check("t3_err_mask", 32'(err0), 32'hC0);
        check("t3_fail_vec", 32'(fvec0), 32'd0);
        check("t3_pass", 32'(pass0), 32'd0);

        // OR stuck-at-0: first failure on vector 01.
        fault_mode = 3;
        run_sweep(0);
        check("t3b_err_mask", 32'(err0), 32'h08);
        check("t3b_fail_vec", 32'(fvec0), 32'd1);
        check("t3b_fail_valid", 32'(fvalid0), 32'd1);

        // start with abort in idle: no sweep, results kept.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t5_start_abort_busy", 32'(busy0), 32'd0);
        check("t5_start_abort_err_kept", 32'(err0), 32'h08);
        tick();
        check("t5_start_abort_still_idle", 32'(busy0), 32'd0);

        // Abort at the 2nd CHECK (cycle k+6), with AND stuck so err is nonzero.
        fault_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_err_cleared_on_start", 32'(err0), 32'h00);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", 32'(busy0), 32'd0);
        check("t4_abort_drv", 32'({drv_a0, drv_b0}), 32'd0);
        check("t4_abort_err_held", 32'(err0), 32'h04);
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            if (done0) seen++;
            tick();
        end
        check("t4_no_done_after_abort", 32'(seen), 32'd0);
        fault_mode = 0;
        run_sweep(0);
        check("t4_restart_latency", 32'(lat0), 32'd13);
        check("t4_restart_err_mask", 32'(err0), 32'h00);
        check("t4_restart_pass", 32'(pass0), 32'd1);

        // start re-pulsed while busy.
        run_sweep(5);
        check("t5_single_done", 32'(nd0), 32'd1);
        check("t5_latency", 32'(lat0), 32'd13);
        check("t5_latency_s1", 32'(lat1), 32'd9);

        // rst mid-sweep while vec=2 (cycle k+7).
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t6_vec2_before_rst", 32'({drv_a0, drv_b0}), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_outputs", 32'(act0), 32'h0);
        tick();
        check("t6_rst_idle", 32'(busy0), 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
